// File: rtl/ipv4_rx.sv
// rtl/ipv4_rx.sv - IPv4 receive stage: header parse/check, checksum, payload trim
// Optional feature macro: IPV4_OPTIONS_EN (accept IHL 5..15, option words summed then skipped)
module ipv4_rx #(
  parameter int          DATA_W   = 16,
  parameter int          LEN_W    = 2,
  parameter logic [31:0] IP_ADDR  = 32'hC0A80001,
  parameter logic [7:0]  PROTOCOL = 8'd17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              valid_o,
  output logic              start_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              cs_err_o,
  output logic              cancel_o
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    HEAD = 4'b0010,
    DATA = 4'b0100,
    DROP = 4'b1000
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;       // header bytes consumed, including the start beat
  logic [15:0] rem_q;       // payload bytes still to forward
  logic [15:0] csum_q;      // folded ones-complement header sum
  logic [15:0] tot_len_q;
  logic [15:0] dst_hi_q;
  logic [15:0] dst_lo_q;
  logic [3:0]  ver_q;
  logic [3:0]  ihl_q;
  logic        frag_bad_q;
  logic [7:0]  proto_q;
  logic        first_q;
  logic        cs_err_q;

  logic [15:0] word_w;
  logic [15:0] len_ext_w;
  logic [16:0] csum_sum_w;
  logic [15:0] csum_fold_w;
  logic [16:0] cnt_sum_w;
  logic [15:0] cnt_next_w;
  logic [15:0] hdr_len_w;
  logic        ihl_ok_w;
  logic [31:0] dst_w;
  logic        hdr_last_w;
  logic        hdr_ok_w;
  logic [15:0] pay_len_w;
  logic        start_beat_w;
  logic        pay_beat_w;
  logic [15:0] rem_next_w;

  // Header datapath: big-endian word, checksum fold, saturating byte count, field checks
  always_comb begin
    word_w      = {data_i[7:0], data_i[15:8]};
    len_ext_w   = {{(16-LEN_W){1'b0}}, len_i};
    csum_sum_w  = {1'b0, csum_q} + {1'b0, word_w};
    csum_fold_w = csum_sum_w[15:0] + {15'd0, csum_sum_w[16]};
    cnt_sum_w   = {1'b0, cnt_q} + {1'b0, len_ext_w};
    cnt_next_w  = cnt_sum_w[16] ? 16'hFFFF : cnt_sum_w[15:0];
`ifdef IPV4_OPTIONS_EN
    ihl_ok_w    = (ihl_q >= 4'd5);
    // A bad IHL still ends the header at 20 bytes so the frame lands in DROP
    hdr_len_w   = ihl_ok_w ? {10'd0, ihl_q, 2'b00} : 16'd20;
`else
    ihl_ok_w    = (ihl_q == 4'd5);
    hdr_len_w   = 16'd20;
`endif
    // The low destination word may be arriving on this very beat
    dst_w       = (cnt_q == 16'd18) ? {dst_hi_q, word_w} : {dst_hi_q, dst_lo_q};
    hdr_last_w  = (state_q == HEAD) && (cnt_next_w == hdr_len_w);
    hdr_ok_w    = (ver_q == 4'd4) && ihl_ok_w && (tot_len_q >= hdr_len_w) &&
                  !frag_bad_q && (proto_q == PROTOCOL) && (dst_w == IP_ADDR);
    pay_len_w   = tot_len_q - hdr_len_w;
  end

  // Payload pass-through: zero latency, trimmed to the remaining byte count
  always_comb begin
    start_beat_w = valid_i & start_i;
    pay_beat_w   = (state_q == DATA) & valid_i & ~start_i & ~cancel_i;
    len_o        = (len_ext_w > rem_q) ? rem_q[LEN_W-1:0] : len_i;
    rem_next_w   = rem_q - {{(16-LEN_W){1'b0}}, len_o};
    valid_o      = pay_beat_w;
    start_o      = pay_beat_w & first_q;
    data_o       = data_i;
    cs_err_o     = cs_err_q;
    cancel_o     = (state_q == DATA) & (cancel_i | start_beat_w);
  end

  // Frame FSM: header capture and checks, payload countdown, abort handling
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      rem_q      <= 16'd0;
      csum_q     <= 16'd0;
      tot_len_q  <= 16'd0;
      dst_hi_q   <= 16'd0;
      dst_lo_q   <= 16'd0;
      ver_q      <= 4'd0;
      ihl_q      <= 4'd0;
      frag_bad_q <= 1'b0;
      proto_q    <= 8'd0;
      first_q    <= 1'b0;
      cs_err_q   <= 1'b0;
    end else if (cancel_i) begin
      state_q <= IDLE;
      first_q <= 1'b0;
    end else if (start_beat_w) begin
      state_q    <= HEAD;
      cnt_q      <= len_ext_w;
      csum_q     <= word_w;
      ver_q      <= data_i[7:4];
      ihl_q      <= data_i[3:0];
      tot_len_q  <= 16'd0;
      dst_hi_q   <= 16'd0;
      dst_lo_q   <= 16'd0;
      frag_bad_q <= 1'b0;
      proto_q    <= 8'd0;
      rem_q      <= 16'd0;
      first_q    <= 1'b0;
      cs_err_q   <= 1'b0;
    end else if (valid_i) begin
      case (state_q)
        HEAD: begin
          cnt_q  <= cnt_next_w;
          csum_q <= csum_fold_w;
          if (cnt_q == 16'd2)  tot_len_q  <= word_w;
          if (cnt_q == 16'd6)  frag_bad_q <= data_i[5] | (|data_i[4:0]) | (|data_i[15:8]);
          if (cnt_q == 16'd8)  proto_q    <= data_i[15:8];
          if (cnt_q == 16'd16) dst_hi_q   <= word_w;
          if (cnt_q == 16'd18) dst_lo_q   <= word_w;
          if (hdr_last_w) begin
            cs_err_q <= (csum_fold_w != 16'hFFFF);
            rem_q    <= pay_len_w;
            first_q  <= 1'b1;
            if (!hdr_ok_w)
              state_q <= DROP;
            else if (pay_len_w == 16'd0)
              state_q <= IDLE;
            else
              state_q <= DATA;
          end
        end
        DATA: begin
          rem_q   <= rem_next_w;
          first_q <= 1'b0;
          if (rem_next_w == 16'd0) state_q <= IDLE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
